// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: PC/back-pressure, instruction-memory port, decode handshake.
// With FETCH_STATS_EN defined, the bus also carries the FetchCnt/FlushCnt statistics outputs.
interface inst_fetch_queue_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned IW    = 9,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  PC;
  logic          PCAdvance;
  logic          Flush;
  logic [W-1:0]  ImemAddr;
  logic          ImemRdEn;
  logic [IW-1:0] ImemData;
  logic          InstValid;
  logic          InstReady;
  logic [IW-1:0] Inst;
  logic [W-1:0]  InstPC;
  logic [CW-1:0] Count;
`ifdef FETCH_STATS_EN
  logic [15:0]   FetchCnt;
  logic [15:0]   FlushCnt;
`else
`endif

  // Fetch queue side
  modport master (
    input  PC, Flush, ImemData, InstReady,
    output PCAdvance, ImemAddr, ImemRdEn, InstValid, Inst, InstPC, Count
`ifdef FETCH_STATS_EN
    , output FetchCnt, FlushCnt
`endif
  );

  // Program counter / memory / decode side
  modport slave (
    output PC, Flush, ImemData, InstReady,
    input  PCAdvance, ImemAddr, ImemRdEn, InstValid, Inst, InstPC, Count
`ifdef FETCH_STATS_EN
    , input FetchCnt, FlushCnt
`endif
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues PC to a synchronous imem, queues {word, PC}, hands to decode.
// Optional FETCH_STATS_EN adds saturating push and flush counters.
module inst_fetch_queue #(
  parameter int unsigned W     = 8,
  parameter int unsigned IW    = 9,
  parameter int unsigned DEPTH = 4
) (
  input logic            Clk,
  input logic            Reset_n,
  inst_fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [W-1:0]  pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [W-1:0]    pc_pipe;

  logic            issue_c;
  logic            push_c;
  logic            pop_c;
  logic            valid_c;
  entry_t          head_c;

  // Issue gate reserves a slot for the in-flight fetch so a push can never overflow
  always_comb begin
    issue_c = 1'b0;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    valid_c = (count != '0);
    head_c  = mem[rd_ptr];
    issue_c = Reset_n & ~bus.Flush & ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
    push_c  = inflight & ~bus.Flush;
    pop_c   = valid_c & bus.InstReady;
  end

  assign bus.ImemAddr  = bus.PC;
  assign bus.ImemRdEn  = issue_c;
  assign bus.PCAdvance = issue_c;
  assign bus.InstValid = valid_c;
  assign bus.Count     = count;
  assign bus.Inst      = valid_c ? head_c.inst : '0;
  assign bus.InstPC    = valid_c ? head_c.pc   : '0;

  // Pointers, occupancy and the one-deep fetch pipe; Flush overrides everything
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      pc_pipe  <= '0;
    end else if (bus.Flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue_c;
      if (issue_c) pc_pipe <= bus.PC;
      if (push_c)  wr_ptr  <= wr_ptr + PW'(1);
      if (pop_c)   rd_ptr  <= rd_ptr + PW'(1);
      count <= count + CW'(push_c) - CW'(pop_c);
    end
  end

  // Storage needs no reset: reads are masked while the queue is empty
  always_ff @(posedge Clk) begin
    if (push_c) mem[wr_ptr] <= '{inst: bus.ImemData, pc: pc_pipe};
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push_c && (fetch_cnt != 16'hFFFF))    fetch_cnt <= fetch_cnt + 16'd1;
      if (bus.Flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.FetchCnt = fetch_cnt;
  assign bus.FlushCnt = flush_cnt;
`else
  // Statistics counters are not built; core behaviour is unaffected.
`endif

endmodule
